// File: rtl/pc_call_stack.sv
// VR16 frontend program counter with a hardware return-address stack,
// PC-relative branches and a RUN/FAULT/HALT stack-fault state machine.
module pc_call_stack #(
    parameter int unsigned           ADDR_WIDTH   = 16,
    parameter int unsigned           STACK_DEPTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = ADDR_WIDTH'(16'hFF00)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ins_count,
    input  logic                         call_enable,
    input  logic                         return_enable,
    input  logic                         branch_enable,
    input  logic [1:0]                   flag_input,
    input  logic                         clear_fault,
    input  logic [ADDR_WIDTH-1:0]        jump_address,
    input  logic [ADDR_WIDTH-1:0]        branch_offset,
    output logic [ADDR_WIDTH-1:0]        counter_reg,
    output logic [$clog2(STACK_DEPTH):0] stack_level,
    output logic                         stack_overflow,
    output logic                         stack_underflow,
    output logic                         fault,
    output logic                         halted
);

    localparam int unsigned IW = $clog2(STACK_DEPTH);
    localparam int unsigned LW = IW + 1;

    typedef enum logic [1:0] {
        S_RUN,
        S_FAULT,
        S_HALT
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [LW-1:0]         r_level;
    logic                  r_ovf;
    logic                  r_unf;
    logic                  r_fault;
    logic                  r_halted;
    logic [ADDR_WIDTH-1:0] r_stack [STACK_DEPTH];

    logic [ADDR_WIDTH-1:0] w_pc_inc;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_ovf;
    logic                  w_unf;
    logic                  w_sfault;
    logic                  w_push;
    logic [IW-1:0]         w_push_idx;
    logic [IW-1:0]         w_pop_idx;

    assign w_pc_inc   = r_pc + ADDR_WIDTH'(1);
    assign w_full     = (r_level == LW'(STACK_DEPTH));
    assign w_empty    = (r_level == '0);
    // A return only faults when no call outranks it in the same cycle.
    assign w_ovf      = call_enable && w_full;
    assign w_unf      = !call_enable && return_enable && w_empty;
    assign w_sfault   = ins_count && (w_ovf || w_unf);
    assign w_push     = (r_state != S_HALT) && ins_count && call_enable && !w_full;
    assign w_push_idx = IW'(r_level);
    assign w_pop_idx  = IW'(r_level - LW'(1));

    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_RUN;
            r_pc     <= RESET_VECTOR;
            r_level  <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_fault  <= 1'b0;
            r_halted <= 1'b0;
        end else if (r_state != S_HALT) begin
            if (ins_count) begin
                if (w_sfault) begin
                    if (w_ovf) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_unf <= 1'b1;
                    end
                    if (r_state == S_RUN) begin
                        r_pc <= TRAP_VECTOR;
                    end
                end else if (call_enable) begin
                    r_pc    <= jump_address;
                    r_level <= r_level + LW'(1);
                end else if (return_enable) begin
                    r_pc    <= r_stack[w_pop_idx];
                    r_level <= r_level - LW'(1);
                end else if (branch_enable) begin
                    r_pc <= r_pc + branch_offset;
                end else if (flag_input == 2'b11) begin
                    r_pc    <= RESET_VECTOR;
                    r_level <= '0;
                end else begin
                    r_pc <= w_pc_inc;
                end
            end

            // A second fault outranks clear_fault; clear_fault ignores ins_count.
            case (r_state)
                S_RUN: begin
                    if (w_sfault) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end
                end
                S_FAULT: begin
                    if (w_sfault) begin
                        r_state  <= S_HALT;
                        r_fault  <= 1'b0;
                        r_halted <= 1'b1;
                    end else if (clear_fault) begin
                        r_state <= S_RUN;
                        r_fault <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign counter_reg     = r_pc;
    assign stack_level     = r_level;
    assign stack_overflow  = r_ovf;
    assign stack_underflow = r_unf;
    assign fault           = r_fault;
    assign halted          = r_halted;

endmodule

// File: tb/tb_pc_call_stack.sv
// Directed vector bench for pc_call_stack with a depth-4 stack.
module tb_pc_call_stack;

    logic        clk = 1'b0;
    logic        reset;
    logic        ins_count;
    logic        call_enable;
    logic        return_enable;
    logic        branch_enable;
    logic [1:0]  flag_input;
    logic        clear_fault;
    logic [15:0] jump_address;
    logic [15:0] branch_offset;
    logic [15:0] counter_reg;
    logic [2:0]  stack_level;
    logic        stack_overflow;
    logic        stack_underflow;
    logic        fault;
    logic        halted;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    pc_call_stack #(
        .ADDR_WIDTH  (16),
        .STACK_DEPTH (4),
        .RESET_VECTOR(16'h0000),
        .TRAP_VECTOR (16'hFF00)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ins_count      (ins_count),
        .call_enable    (call_enable),
        .return_enable  (return_enable),
        .branch_enable  (branch_enable),
        .flag_input     (flag_input),
        .clear_fault    (clear_fault),
        .jump_address   (jump_address),
        .branch_offset  (branch_offset),
        .counter_reg    (counter_reg),
        .stack_level    (stack_level),
        .stack_overflow (stack_overflow),
        .stack_underflow(stack_underflow),
        .fault          (fault),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        ins;
        logic        call;
        logic        ret;
        logic        br;
        logic [1:0]  flag;
        logic        clr;
        logic [15:0] jaddr;
        logic [15:0] boff;
        logic [15:0] pc;
        logic [2:0]  lvl;
        logic [3:0]  flags;   // {overflow, underflow, fault, halted}
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst_n, logic ins, logic call, logic ret, logic br,
                                logic [1:0] flag, logic clr, logic [15:0] jaddr,
                                logic [15:0] boff, logic [15:0] pc, logic [2:0] lvl,
                                logic [3:0] flags);
        vec_t v;
        v.rst_n = rst_n; v.ins = ins; v.call = call; v.ret = ret; v.br = br;
        v.flag = flag; v.clr = clr; v.jaddr = jaddr; v.boff = boff;
        v.pc = pc; v.lvl = lvl; v.flags = flags;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(vec_t v, string tag);
        reset         = v.rst_n;
        ins_count     = v.ins;
        call_enable   = v.call;
        return_enable = v.ret;
        branch_enable = v.br;
        flag_input    = v.flag;
        clear_fault   = v.clr;
        jump_address  = v.jaddr;
        branch_offset = v.boff;
        @(posedge clk);
        #1;
        chk({tag, ".pc"}, 32'(counter_reg), 32'(v.pc));
        chk({tag, ".level"}, 32'(stack_level), 32'(v.lvl));
        chk({tag, ".flags"}, 32'({stack_overflow, stack_underflow, fault, halted}), 32'(v.flags));
    endtask

    initial begin
        // Reset and plain increments; reset overrides a simultaneous call.
        vecs.push_back(mk(0,0,0,0,0,2'b00,0,16'h0000,16'h0000, 16'h0000,3'd0,4'b0000));
        vecs.push_back(mk(1,1,0,0,0,2'b00,0,16'h0000,16'h0000, 16'h0001,3'd0,4'b0000));
        vecs.push_back(mk(1,1,0,0,0,2'b00,0,16'h0000,16'h0000, 16'h0002,3'd0,4'b0000));
        vecs.push_back(mk(1,1,0,0,0,2'b00,0,16'h0000,16'h0000, 16'h0003,3'd0,4'b0000));
        vecs.push_back(mk(0,1,1,0,0,2'b00,0,16'h1234,16'h0000, 16'h0000,3'd0,4'b0000));
        for (int k = 1; k <= 5; k++)
            vecs.push_back(mk(1,1,0,0,0,2'b00,0,16'h0000,16'h0000, 16'(k),3'd0,4'b0000));
        // Nested call / return.
        vecs.push_back(mk(1,1,1,0,0,2'b00,0,16'h0100,16'h0000, 16'h0100,3'd1,4'b0000));
        vecs.push_back(mk(1,1,0,0,0,2'b00,0,16'h0000,16'h0000, 16'h0101,3'd1,4'b0000));
        vecs.push_back(mk(1,1,1,0,0,2'b00,0,16'h0200,16'h0000, 16'h0200,3'd2,4'b0000));
        vecs.push_back(mk(1,1,0,1,0,2'b00,0,16'h0000,16'h0000, 16'h0102,3'd1,4'b0000));
        vecs.push_back(mk(1,1,0,1,0,2'b00,0,16'h0000,16'h0000, 16'h0006,3'd0,4'b0000));
        // Branches, wrap, pushed return of all-ones+1, return beats branch.
        vecs.push_back(mk(1,1,0,0,1,2'b00,0,16'h0000,16'h000A, 16'h0010,3'd0,4'b0000));
        vecs.push_back(mk(1,1,0,0,1,2'b00,0,16'h0000,16'hFFF0, 16'h0000,3'd0,4'b0000));
        vecs.push_back(mk(1,1,0,0,1,2'b00,0,16'h0000,16'hFFFF, 16'hFFFF,3'd0,4'b0000));
        vecs.push_back(mk(1,1,0,0,0,2'b00,0,16'h0000,16'h0000, 16'h0000,3'd0,4'b0000));
        vecs.push_back(mk(1,1,0,0,1,2'b00,0,16'h0000,16'hFFFF, 16'hFFFF,3'd0,4'b0000));
        vecs.push_back(mk(1,1,1,0,0,2'b00,0,16'h0300,16'h0000, 16'h0300,3'd1,4'b0000));
        vecs.push_back(mk(1,1,0,1,1,2'b00,0,16'h0000,16'h0050, 16'h0000,3'd0,4'b0000));
        // Priority, ins_count gating, soft restart.
        vecs.push_back(mk(1,1,1,1,0,2'b11,0,16'h0400,16'h0000, 16'h0400,3'd1,4'b0000));
        vecs.push_back(mk(1,0,1,0,0,2'b00,0,16'h0500,16'h0000, 16'h0400,3'd1,4'b0000));
        vecs.push_back(mk(1,1,1,0,0,2'b00,0,16'h0500,16'h0000, 16'h0500,3'd2,4'b0000));
        vecs.push_back(mk(1,1,0,0,0,2'b11,0,16'h0000,16'h0000, 16'h0000,3'd0,4'b0000));
        // Fill the stack, overflow, clear_fault keeps the sticky flag.
        vecs.push_back(mk(1,1,1,0,0,2'b00,0,16'h0010,16'h0000, 16'h0010,3'd1,4'b0000));
        vecs.push_back(mk(1,1,1,0,0,2'b00,0,16'h0020,16'h0000, 16'h0020,3'd2,4'b0000));
        vecs.push_back(mk(1,1,1,0,0,2'b00,0,16'h0030,16'h0000, 16'h0030,3'd3,4'b0000));
        vecs.push_back(mk(1,1,1,0,0,2'b00,0,16'h0040,16'h0000, 16'h0040,3'd4,4'b0000));
        vecs.push_back(mk(1,1,1,0,0,2'b00,0,16'h0050,16'h0000, 16'hFF00,3'd4,4'b1010));
        vecs.push_back(mk(1,0,0,0,0,2'b00,1,16'h0000,16'h0000, 16'hFF00,3'd4,4'b1000));
        vecs.push_back(mk(1,1,0,0,0,2'b00,0,16'h0000,16'h0000, 16'hFF01,3'd4,4'b1000));
        vecs.push_back(mk(1,1,0,1,0,2'b00,0,16'h0000,16'h0000, 16'h0031,3'd3,4'b1000));
        // Underflow in RUN, normal step in FAULT, second underflow halts.
        vecs.push_back(mk(1,1,0,0,0,2'b11,0,16'h0000,16'h0000, 16'h0000,3'd0,4'b1000));
        vecs.push_back(mk(1,1,0,1,0,2'b00,0,16'h0000,16'h0000, 16'hFF00,3'd0,4'b1110));
        vecs.push_back(mk(1,1,0,0,0,2'b00,0,16'h0000,16'h0000, 16'hFF01,3'd0,4'b1110));
        vecs.push_back(mk(1,1,0,1,0,2'b00,0,16'h0000,16'h0000, 16'hFF01,3'd0,4'b1101));

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("v%0d", i));

        // HALT ignores commands and clear_fault; only reset leaves it.
        apply(mk(1,1,1,0,0,2'b00,0,16'h0700,16'h0000, 16'hFF01,3'd0,4'b1101), "halt_call");
        apply(mk(1,1,0,0,0,2'b00,1,16'h0000,16'h0000, 16'hFF01,3'd0,4'b1101), "halt_clr");
        apply(mk(1,1,0,0,1,2'b11,0,16'h0000,16'h0010, 16'hFF01,3'd0,4'b1101), "halt_br");
        apply(mk(0,0,0,0,0,2'b00,0,16'h0000,16'h0000, 16'h0000,3'd0,4'b0000), "halt_rst");

        // Overflow twice: trap, then halt with PC held at the trap vector.
        for (int k = 0; k < 4; k++)
            apply(mk(1,1,1,0,0,2'b00,0,16'h0A00 + 16'(k),16'h0000,
                     16'h0A00 + 16'(k),3'(k + 1),4'b0000), $sformatf("ovf_fill%0d", k));
        apply(mk(1,1,1,0,0,2'b00,0,16'h0B00,16'h0000, 16'hFF00,3'd4,4'b1010), "ovf_first");
        apply(mk(1,1,1,0,0,2'b00,0,16'h0B00,16'h0000, 16'hFF00,3'd4,4'b1001), "ovf_second");
        apply(mk(1,1,0,1,0,2'b00,0,16'h0000,16'h0000, 16'hFF00,3'd4,4'b1001), "ovf_frozen");
        apply(mk(0,1,0,0,0,2'b00,0,16'h0000,16'h0000, 16'h0000,3'd0,4'b0000), "ovf_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
